// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port memory bus arbiter: FSM state
// encodings, requester port IDs and the default timeout length.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_bus_arbiter_bus_timer.sv
// Transaction watchdog counter: counts up while enabled, returns to zero
// on clear, and flags the last cycle before the timeout limit.
module bus_timer #(
  parameter int TW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [TW-1:0] count,
  output logic          expire
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  // Counter register: clear wins over enable so each transaction starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the cpu (port 0) and
// the aux/DMA requester (port 1). One transaction is outstanding at a time;
// a watchdog aborts transactions that memory never acknowledges. All
// outputs come straight from registers.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] m0_address,
  input  logic [DW-1:0] m0_data_out,
  input  logic          m0_read,
  input  logic          m0_write,
  output logic [DW-1:0] m0_data_in,
  output logic          m0_ready,
  output logic          m0_error,
  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m1_data_out,
  input  logic          m1_read,
  input  logic          m1_write,
  output logic [DW-1:0] m1_data_in,
  output logic          m1_ready,
  output logic          m1_error,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_out,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_data_in,
  input  logic          mem_ready,
  output logic          grant,
  output logic          busy
);

  state_t state, state_nxt;
  logic   prio, prio_nxt;

  logic          grant_nxt, busy_nxt;
  logic [AW-1:0] mem_address_nxt;
  logic [DW-1:0] mem_data_out_nxt;
  logic          mem_read_nxt, mem_write_nxt;
  logic [DW-1:0] m0_data_in_nxt, m1_data_in_nxt;
  logic          m0_ready_nxt, m0_error_nxt, m1_ready_nxt, m1_error_nxt;

  logic          req0, req1, pick;
  logic          pick_read, pick_write;
  logic [AW-1:0] pick_address;
  logic [DW-1:0] pick_data;

  logic          done_now, done_err, done_zero;

  logic [TW-1:0] tmr_count;
  logic          tmr_expire;

  // The watchdog only runs in BUSY; leaving BUSY rearms it at zero.
  bus_timer #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_BUSY),
    .enable ((state == ST_BUSY) && !mem_ready),
    .count  (tmr_count),
    .expire (tmr_expire)
  );

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Round-robin pick and request mux; the pointer breaks ties only.
  always_comb begin
    pick = PORT_CPU;
    if (req0 && req1) begin
      pick = prio;
    end else if (req1) begin
      pick = PORT_AUX;
    end else begin
      pick = PORT_CPU;
    end
    if (pick == PORT_AUX) begin
      pick_read    = m1_read;
      pick_write   = m1_write;
      pick_address = m1_address;
      pick_data    = m1_data_out;
    end else begin
      pick_read    = m0_read;
      pick_write   = m0_write;
      pick_address = m0_address;
      pick_data    = m0_data_out;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_nxt        = state;
    prio_nxt         = prio;
    grant_nxt        = grant;
    busy_nxt         = busy;
    mem_address_nxt  = mem_address;
    mem_data_out_nxt = mem_data_out;
    mem_read_nxt     = mem_read;
    mem_write_nxt    = mem_write;
    done_now         = 1'b0;
    done_err         = 1'b0;
    done_zero        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_nxt = pick;
          busy_nxt  = 1'b1;
          if (pick_read && pick_write) begin
            // Protocol error: never touch memory, complete with error.
            state_nxt = ST_DONE;
            done_now  = 1'b1;
            done_err  = 1'b1;
            done_zero = 1'b1;
          end else begin
            state_nxt        = ST_BUSY;
            mem_address_nxt  = pick_address;
            mem_data_out_nxt = pick_data;
            mem_read_nxt     = pick_read;
            mem_write_nxt    = pick_write;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          // Acknowledge beats timeout, even in the final watchdog cycle.
          state_nxt     = ST_DONE;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          done_now      = 1'b1;
        end else if (tmr_expire) begin
          state_nxt     = ST_DONE;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          done_now      = 1'b1;
          done_err      = 1'b1;
          done_zero     = mem_read;
        end else begin
          state_nxt = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
        prio_nxt  = ~grant;
      end
      default: begin
        state_nxt     = ST_IDLE;
        busy_nxt      = 1'b0;
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
      end
    endcase
  end

  // Steer the completion pulse and read data to the owning port only.
  always_comb begin
    m0_ready_nxt   = 1'b0;
    m0_error_nxt   = 1'b0;
    m1_ready_nxt   = 1'b0;
    m1_error_nxt   = 1'b0;
    m0_data_in_nxt = m0_data_in;
    m1_data_in_nxt = m1_data_in;
    if (done_now) begin
      if (grant_nxt == PORT_AUX) begin
        m1_ready_nxt = 1'b1;
        m1_error_nxt = done_err;
        if (done_zero) begin
          m1_data_in_nxt = '0;
        end else if (mem_read && mem_ready) begin
          m1_data_in_nxt = mem_data_in;
        end else begin
          m1_data_in_nxt = m1_data_in;
        end
      end else begin
        m0_ready_nxt = 1'b1;
        m0_error_nxt = done_err;
        if (done_zero) begin
          m0_data_in_nxt = '0;
        end else if (mem_read && mem_ready) begin
          m0_data_in_nxt = mem_data_in;
        end else begin
          m0_data_in_nxt = m0_data_in;
        end
      end
    end else begin
      m0_ready_nxt = 1'b0;
    end
  end

  // State and output registers; reset clears everything and favours port 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      prio         <= PORT_CPU;
      grant        <= 1'b0;
      busy         <= 1'b0;
      mem_address  <= '0;
      mem_data_out <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      m0_data_in   <= '0;
      m0_ready     <= 1'b0;
      m0_error     <= 1'b0;
      m1_data_in   <= '0;
      m1_ready     <= 1'b0;
      m1_error     <= 1'b0;
    end else begin
      state        <= state_nxt;
      prio         <= prio_nxt;
      grant        <= grant_nxt;
      busy         <= busy_nxt;
      mem_address  <= mem_address_nxt;
      mem_data_out <= mem_data_out_nxt;
      mem_read     <= mem_read_nxt;
      mem_write    <= mem_write_nxt;
      m0_data_in   <= m0_data_in_nxt;
      m0_ready     <= m0_ready_nxt;
      m0_error     <= m0_error_nxt;
      m1_data_in   <= m1_data_in_nxt;
      m1_ready     <= m1_ready_nxt;
      m1_error     <= m1_error_nxt;
    end
  end

endmodule
